ram_pair_reader: RTL and testbench
==================================

# ram_pair_reader

Command-driven read sequencer that sits directly downstream of the 64x16 single-write / dual-async-read RAM. It drives both read addresses, walks two independent address streams in lockstep, and captures each read pair into a registered output beat. Each beat carries both words and their zero-extended sum over a valid/ready interface with full backpressure. Software or a control FSM issues one command per block transfer and receives a one-cycle completion pulse.

## Interface
- AW, 6, RAM address width (RAM depth 2^AW)
- DW, 16, RAM data width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- base1  in  AW  first address of stream 1
- base2  in  AW  first address of stream 2
- len  in  AW  pair count minus one (0 = 1 pair, 2^AW-1 = 2^AW pairs)
- busy  out  1  high while in RUN or DRAIN
- ra1  out  AW  RAM read address, port 1 (registered)
- ra2  out  AW  RAM read address, port 2 (registered)
- do1  in  DW  RAM async read data, port 1
- do2  in  DW  RAM async read data, port 2
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_data1  out  DW  captured word from stream 1
- m_data2  out  DW  captured word from stream 2
- m_sum  out  DW+1  m_data1 + m_data2, zero-extended, no overflow
- m_last  out  1  marks final beat of the command
- done  out  1  one-cycle pulse when final beat is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 loads ptr1=base1, ptr2=base2, cnt=len, and moves to RUN. start is ignored in RUN and DRAIN; no queueing.
- ra1/ra2 are the ptr1/ptr2 registers.
- Output register is free when m_valid=0 or (m_valid & m_ready).
- RUN, output register free: capture do1/do2 into m_data1/m_data2, compute m_sum, set m_valid=1, then:
  - increment ptr1 and ptr2 mod 2^AW; 2^AW-1 wraps to 0 independently per stream.
  - if cnt==0: set m_last=1 and move to DRAIN; otherwise decrement cnt with m_last=0.
- RUN, output register not free: hold all state, including pointers, cnt and the output beat.
- m_data1, m_data2, m_sum and m_last are stable while m_valid=1 and m_ready=0.
- DRAIN: when m_valid & m_ready, clear m_valid and m_last, pulse done, and return to IDLE.
- Same-edge RAM write to an address being read: the captured word is the pre-write RAM content (async read sampled at that edge).
- ra1==ra2 is legal; both outputs carry the same word.
- Reset, async and at any time including mid-transfer: state=IDLE; ptr1, ptr2, cnt, ra1, ra2, m_data1, m_data2, m_sum = 0; m_valid, m_last, done, busy = 0. The in-flight beat is discarded and no done is issued.

## Timing
- start sampled at edge E0: busy=1 and ra1=base1, ra2=base2 after E0.
- First beat captured at E1: m_valid=1 after E1, giving 1 cycle of start-to-valid latency.
- With m_ready held high, one beat per cycle. N=len+1 beats occupy edges E1..EN.
- Final accept at EN+1: done=1 for the cycle after EN+1, busy=0 after EN+1. A new start is accepted at the edge after that.
- busy is combinational from state (RUN or DRAIN); all other outputs are registered.
- Backpressure stall of k cycles delays every later edge by k; no beat is dropped or duplicated.

## Test plan
- RAM preloaded with mem[i]=i; start, base1=0, base2=32, len=3, m_ready=1 -> beats (0,32,32), (1,33,34), (2,34,36), (3,35,38); m_last on the 4th beat; done 1 cycle after it.
- Wrap: base1=62, base2=63, len=2 -> ra1 sequence 62,63,0 and ra2 sequence 63,0,1; data matches the preload.
- Overflow: mem[5]=16'hFFFF, mem[6]=16'hFFFF, base1=5, base2=6, len=0 -> m_sum=17'h1FFFE; m_last=1 on the single beat.
- Backpressure: len=7, m_ready toggling 1,0,0,1,... -> exactly 8 beats, each held stable while stalled, in order; start pulses during busy are ignored.
- Reset mid-transfer: assert rst after the 3rd beat of len=15 -> all outputs 0 immediately and no done; a new command after reset runs cleanly from its own base.
- Write collision: same edge as the capture of address 10, RAM write di=16'hABCD to address 10 -> captured word is the old value; the next command reading 10 returns 16'hABCD.

Source files
------------

// File: rtl/ram_pair_reader.sv
// ram_pair_reader: walks two RAM read streams in lockstep and emits (word1, word2, sum) beats over valid/ready
module ram_pair_reader #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base1,
  input  logic [AW-1:0] base2,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] do1,
  input  logic [DW-1:0] do2,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data1,
  output logic [DW-1:0] m_data2,
  output logic [DW:0]   m_sum,
  output logic          m_last,
  output logic          done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr1, r_ptr2, r_cnt;
  logic          r_valid, r_last, r_done;
  logic [DW-1:0] r_data1, r_data2;
  logic [DW:0]   r_sum;
  logic          w_free, w_capture, w_final;

  assign w_free    = !r_valid || m_ready;
  assign w_capture = (r_state == S_RUN) && w_free;
  assign w_final   = (r_state == S_DRAIN) && r_valid && m_ready;

  // FSM, address pointers and remaining-pair counter; pointers only advance on a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr1  <= '0;
      r_ptr2  <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_state <= S_RUN;
      r_ptr1  <= base1;
      r_ptr2  <= base2;
      r_cnt   <= len;
    end else if (w_capture) begin
      r_ptr1  <= r_ptr1 + 1'b1;
      r_ptr2  <= r_ptr2 + 1'b1;
      r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
      r_state <= (r_cnt == '0) ? S_DRAIN : S_RUN;
    end else if (w_final) begin
      r_state <= S_IDLE;
    end
  end

  // Output beat register: loads a fresh pair whenever free in RUN, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_sum   <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_last  <= (r_cnt == '0);
      r_data1 <= do1;
      r_data2 <= do2;
      r_sum   <= {1'b0, do1} + {1'b0, do2};
    end else if (w_final) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // Completion pulse on the cycle after the final beat is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_final;
  end

  assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign ra1     = r_ptr1;
  assign ra2     = r_ptr2;
  assign m_valid = r_valid;
  assign m_last  = r_last;
  assign m_data1 = r_data1;
  assign m_data2 = r_data2;
  assign m_sum   = r_sum;
  assign done    = r_done;
endmodule

// File: tb/tb_ram_pair_reader.sv
// tb_ram_pair_reader: scoreboard bench with a behavioural RAM and randomized backpressure
module tb_ram_pair_reader;
  localparam int AW = 6;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW:0]   s;
    logic          last;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b1;
  logic [AW-1:0] base1 = '0, base2 = '0, len = '0;
  logic busy, m_valid, m_last, done;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] do1, do2, m_data1, m_data2;
  logic [DW:0] m_sum;
  logic [DW-1:0] mem [64];
  logic we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] di = '0;

  beat_t q[$];
  beat_t held;
  bit hold_v = 0, exp_done = 0;
  int checks = 0, errors = 0, beats = 0, ready_mode = 0;

  ram_pair_reader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base1(base1), .base2(base2), .len(len),
    .busy(busy), .ra1(ra1), .ra2(ra2), .do1(do1), .do2(do2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data1(m_data1), .m_data2(m_data2),
    .m_sum(m_sum), .m_last(m_last), .done(done)
  );

  always #5 clk = ~clk;

  assign do1 = mem[ra1];
  assign do2 = mem[ra2];
  always @(posedge clk) if (we) mem[wa] <= di;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks done timing, stall stability and pops the scoreboard on each accepted beat
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (done || exp_done) begin
        chk("done", 64'(done), 64'(exp_done));
        exp_done = 0;
      end
      if (hold_v) begin
        chk("held_valid", 64'(m_valid), 64'd1);
        chk("held_beat", 64'({m_data1, m_data2, m_sum, m_last}), 64'(held));
      end
      hold_v = m_valid && !m_ready;
      held = '{m_data1, m_data2, m_sum, m_last};
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("data1", 64'(m_data1), 64'(e.d1));
          chk("data2", 64'(m_data2), 64'(e.d2));
          chk("sum", 64'(m_sum), 64'(e.s));
          chk("last", 64'(m_last), 64'(e.last));
        end
        if (m_last) exp_done = 1;
        beats++;
      end
    end
  end

  // Downstream ready: always, fixed 1,0,0 pattern, or random
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      m_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (k % 3 == 1) : 1'($urandom_range(0, 1));
    end
  end

  task automatic push_expected(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [AW-1:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      beat_t e;
      logic [AW-1:0] a1, a2;
      a1 = b1 + AW'(i);
      a2 = b2 + AW'(i);
      e.d1 = mem[a1];
      e.d2 = mem[a2];
      e.s = {1'b0, mem[a1]} + {1'b0, mem[a2]};
      e.last = (i == int'(l));
      q.push_back(e);
    end
  endtask

  task automatic cmd(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [AW-1:0] l, input bit spur);
    @(negedge clk);
    start = 1'b1; base1 = b1; base2 = b2; len = l;
    push_expected(b1, b2, l);
    @(negedge clk);
    start = 1'b0;
    base1 = AW'($urandom); base2 = AW'($urandom); len = AW'($urandom);
    if (spur) begin
      for (int i = 0; i < 4; i++) begin
        if (busy) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || q.size() != 0 || exp_done) && t < 2000) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("idle_timeout", 64'(t < 2000), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_last"}, 64'(m_last), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ra"}, 64'({ra1, ra2}), 64'd0);
    chk({tag, "_data"}, 64'({m_data1, m_data2, m_sum}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b0, t;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    cmd(6'd0, 6'd32, 6'd3, 0);
    wait_idle();
    cmd(6'd62, 6'd63, 6'd2, 0);
    wait_idle();
    mem[5] = 16'hFFFF;
    mem[6] = 16'hFFFF;
    cmd(6'd5, 6'd6, 6'd0, 0);
    wait_idle();
    ready_mode = 1;
    b0 = beats;
    cmd(6'd8, 6'd40, 6'd7, 1);
    wait_idle();
    chk("bp_beats", 64'(beats - b0), 64'd8);
    ready_mode = 0;
    b0 = beats;
    cmd(6'd16, 6'd48, 6'd15, 0);
    t = 0;
    while (beats < b0 + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_wait", 64'(t < 200), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    q.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_nodone", 64'(done), 64'd0);
    cmd(6'd20, 6'd21, 6'd1, 0);
    wait_idle();
    @(negedge clk);
    start = 1'b1; base1 = 6'd10; base2 = 6'd10; len = 6'd0;
    push_expected(6'd10, 6'd10, 6'd0);
    @(negedge clk);
    start = 1'b0;
    we = 1'b1; wa = 6'd10; di = 16'hABCD;
    @(negedge clk);
    we = 1'b0;
    wait_idle();
    cmd(6'd10, 6'd11, 6'd0, 0);
    wait_idle();
    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      cmd(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 9)), n[0]);
      wait_idle();
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
